// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
package imem_pkg;

  typedef enum logic [1:0] {CLEAR, LOAD, RUN} imem_state_t;

  // CBZ XZR,#0 -- a branch-to-self that parks the core.
  localparam logic [31:0] HALT_WORD = 32'hb400001f;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x N storage: one synchronous write port and one registered read port.
module imem_ram #(
  parameter int N      = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [N-1:0]      wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [N-1:0]      rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [N-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds its value between fetches; cleared so q starts at zero.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_loadable.sv
// Writable instruction memory: clear sweep, word-by-word program load, then
// registered one-cycle fetch for the pipelined core.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int          N         = 32,
  parameter int          ADDR_W    = 6,
  parameter logic [N-1:0] FILL_WORD = HALT_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reload,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [N-1:0]      ld_data,
  input  logic              ld_last,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [N-1:0]      q,
  output logic              q_valid,
  output logic              busy,
  output logic [ADDR_W:0]   ld_count
);

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  imem_state_t       state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic              ld_fire;
  logic              we;
  logic              re;
  logic [N-1:0]      wdata;
  logic              vld_p1;

  // Writes only happen outside RUN and reads only inside it, so the two
  // RAM ports never touch the same word in the same cycle.
  assign ld_fire = ld_valid && (state == LOAD);
  assign we      = (state == CLEAR) || ld_fire;
  assign wdata   = (state == CLEAR) ? FILL_WORD : ld_data;
  assign re      = fetch_req && (state == RUN);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    unique case (state)
      CLEAR: begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == PTR_MAX) begin
          state_nxt = LOAD;
          ptr_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      LOAD: begin
        if (ld_fire) begin
          cnt_nxt = cnt + 1'b1;
          // Pointer saturates at the top word instead of wrapping.
          ptr_nxt = (ptr == PTR_MAX) ? ptr : ptr + 1'b1;
          if (ld_last || (ptr == PTR_MAX)) state_nxt = RUN;
        end
      end
      RUN: begin
        if (reload) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= CLEAR;
      ptr    <= '0;
      cnt    <= '0;
      vld_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      cnt    <= cnt_nxt;
      vld_p1 <= re;
    end
  end

  // ---- p1: registered read data and its valid ----
  imem_ram #(
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (reset),
    .we    (we),
    .waddr (ptr),
    .wdata (wdata),
    .re    (re),
    .raddr (fetch_addr),
    .rdata (q)
  );

  assign q_valid  = vld_p1;
  assign busy     = (state != RUN);
  assign ld_ready = (state == LOAD);
  assign ld_count = cnt;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed, table-driven bench for imem_loadable.
module tb_imem_loadable;

  localparam logic [31:0] HALT = 32'hb400001f;

  logic        clk = 1'b0;
  logic        reset, reload, ld_valid, ld_ready, ld_last, fetch_req;
  logic [31:0] ld_data, q;
  logic [5:0]  fetch_addr;
  logic        q_valid, busy;
  logic [6:0]  ld_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] exp;
  } fvec_t;

  fvec_t       tbl [17];
  logic [31:0] prog16 [16];
  logic [31:0] src [64];

  imem_loadable dut (
    .clk        (clk),
    .reset      (reset),
    .reload     (reload),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .q          (q),
    .q_valid    (q_valid),
    .busy       (busy),
    .ld_count   (ld_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Counts edges until ld_ready rises (end of clear sweep), bounded.
  task automatic wait_sweep(input string name);
    int cyc = 0;
    while (cyc < 200) begin
      tick();
      cyc++;
      if (ld_ready) break;
    end
    check(name, cyc, 64);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  // Loads src[0..n-1]; optional ld_last on the final word, optional idle gaps.
  task automatic load_words(input int n, input bit use_last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 3 == 1)) begin
        ld_valid = 1'b0;
        tick();
      end
      ld_valid = 1'b1;
      ld_data  = src[i];
      ld_last  = use_last && (i == n - 1);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic fetch(input string name, input logic [5:0] a, input logic [31:0] exp);
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
    fetch_req  = 1'b0;
    check({name, "_vld"}, q_valid, 1);
    check(name, q, exp);
  endtask

  initial begin
    prog16 = '{32'h8b1f03c9, 32'h91000529, 32'hf8000002, 32'h8b010042,
               32'h8b080000, 32'hcb010129, 32'hf8400003, 32'h8b0a0108,
               32'hd1000529, 32'hb4000049, 32'h17fffffc, 32'hf8008002,
               32'haa0103e2, 32'h8b1f03ff, 32'hd503201f, 32'hb400001f};
    for (int i = 0; i < 16; i++) tbl[i] = '{addr: 6'(i), exp: prog16[i]};
    tbl[16] = '{addr: 6'd16, exp: HALT};

    reset = 1'b1; reload = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    ld_data = '0; fetch_req = 1'b0; fetch_addr = '0;

    // Reset and clear sweep; fetches during the sweep are ignored.
    tick(); tick();
    check("rst_busy", busy, 1);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_q_valid", q_valid, 0);
    check("rst_q", q, 0);
    check("rst_ld_count", ld_count, 0);
    reset = 1'b0;
    fetch_req = 1'b1; fetch_addr = 6'd5;
    wait_sweep("sweep_len_boot");
    fetch_req = 1'b0;
    check("clear_fetch_ignored_vld", q_valid, 0);
    check("clear_fetch_ignored_q", q, 0);
    check("load_busy", busy, 1);

    // One-word load, then an unwritten address returns the halt word.
    src[0] = 32'h8b1f03c9;
    load_words(1, 1'b1, 1'b0);
    check("one_word_count", ld_count, 1);
    check("one_word_busy", busy, 0);
    fetch("halt_addr37", 6'd37, HALT);

    // 16-word program with handshake gaps; reload in LOAD must be ignored.
    do_reload();
    wait_sweep("sweep_len_prog16");
    do_reload();
    check("reload_in_load_ignored", ld_ready, 1);
    for (int i = 0; i < 16; i++) src[i] = prog16[i];
    load_words(16, 1'b1, 1'b1);
    check("p16_count", ld_count, 16);
    check("p16_busy", busy, 0);
    check("p16_ld_ready", ld_ready, 0);
    for (int i = 0; i < 17; i++) fetch($sformatf("tbl_addr%0d", tbl[i].addr), tbl[i].addr, tbl[i].exp);
    tick();
    check("idle_q_valid", q_valid, 0);
    check("idle_q_hold", q, HALT);

    // Load attempts in RUN must not write.
    ld_valid = 1'b1; ld_data = 32'hdeadbeef;
    tick();
    ld_valid = 1'b0;
    check("run_ld_ignored_count", ld_count, 16);
    fetch("run_ld_ignored_addr0", 6'd0, prog16[0]);

    // Back-to-back fetches 3,4,5.
    fetch_req = 1'b1;
    for (int i = 3; i <= 5; i++) begin
      fetch_addr = 6'(i);
      tick();
      check($sformatf("b2b_vld%0d", i), q_valid, 1);
      check($sformatf("b2b_q%0d", i), q, prog16[i]);
    end
    fetch_req = 1'b0;

    // Reload with a same-cycle fetch: fetch still served, then full sweep.
    reload = 1'b1; fetch_req = 1'b1; fetch_addr = 6'd2;
    tick();
    reload = 1'b0; fetch_req = 1'b0;
    check("reload_fetch_vld", q_valid, 1);
    check("reload_fetch_q", q, 32'hf8000002);
    check("reload_busy", busy, 1);
    wait_sweep("sweep_len_reload");
    src[0] = HALT;
    load_words(1, 1'b1, 1'b0);
    fetch("after_reload_addr2", 6'd2, HALT);

    // Full 64-word load with no ld_last; 65th word refused.
    do_reload();
    wait_sweep("sweep_len_p64");
    for (int i = 0; i < 64; i++) src[i] = 32'h10000000 + 32'(i) * 32'h00010003;
    load_words(64, 1'b0, 1'b0);
    check("p64_count", ld_count, 64);
    check("p64_busy", busy, 0);
    check("p64_ld_ready", ld_ready, 0);
    ld_valid = 1'b1; ld_data = 32'hdeadbeef;
    tick();
    ld_valid = 1'b0;
    check("p64_extra_count", ld_count, 64);
    fetch("p64_addr0", 6'd0, src[0]);
    fetch("p64_addr63", 6'd63, src[63]);

    // Reset in the middle of LOAD restarts the sweep.
    do_reload();
    wait_sweep("sweep_len_mid");
    for (int i = 0; i < 5; i++) src[i] = prog16[i];
    load_words(5, 1'b0, 1'b0);
    check("mid_count5", ld_count, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_count", ld_count, 0);
    check("mid_rst_ld_ready", ld_ready, 0);
    check("mid_rst_busy", busy, 1);
    wait_sweep("sweep_len_after_rst");
    src[0] = HALT;
    load_words(1, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) fetch($sformatf("wiped_addr%0d", i), 6'(i), HALT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
